// File: rtl/slice_seq_arbiter.sv
// -----------------------------------------------------------------------------
// slice_seq_arbiter
//
// Shares one external 3-bit combinational slice unit between two requesters.
// An accepted operand pair (3*NSLICE bits each) is streamed through the slice
// unit one 3-bit chunk per cycle, LSB chunk first. The reassembled result is
// returned on a valid/ready response port, tagged with the requester ID.
//
// Optional feature macro: SLICE_SEQ_CHECK_EN
//   When defined, each chunk returned by the slice unit is compared against
//   the golden slice function, and any mismatch sets a sticky err flag.
//   When undefined, err is tied to 0 and no comparator is built.
//
// Ports
//   clk                      clock, rising edge
//   rst                      synchronous active-high reset
//   req0_valid / req1_valid  requester has an operand pair
//   req0_ready / req1_ready  requester accepted this cycle (combinational)
//   req0_a/_b, req1_a/_b     operands, 3*NSLICE bits
//   rsp_valid / rsp_ready    response handshake
//   rsp_y                    assembled result
//   rsp_id                   requester that owns rsp_y
//   su_a, su_b               chunk driven to the slice unit (0 outside RUN)
//   su_y                     slice unit output
//   busy                     transaction in progress (RUN or DONE)
//   err                      sticky slice-check error
// -----------------------------------------------------------------------------
module slice_seq_arbiter #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3*NSLICE-1:0]   req0_a,
  input  logic [3*NSLICE-1:0]   req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3*NSLICE-1:0]   req1_a,
  input  logic [3*NSLICE-1:0]   req1_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [3*NSLICE-1:0]   rsp_y,
  output logic                  rsp_id,
  output logic [2:0]            su_a,
  output logic [2:0]            su_b,
  input  logic [2:0]            su_y,
  output logic                  busy,
  output logic                  err
);

  localparam int W  = 3 * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_prio;     // 0: requester 0 has priority, 1: requester 1
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_y;
  logic          r_id;

  logic          w_idle;
  logic          w_run;
  logic          w_done;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_last;
  logic [2:0]    w_su_a;
  logic [2:0]    w_su_b;

  assign w_idle = (r_state == S_IDLE);
  assign w_run  = (r_state == S_RUN);
  assign w_done = (r_state == S_DONE);

  // A lone valid always wins; with both valid, the pointer decides.
  assign w_gnt0 = w_idle & req0_valid & (~req1_valid | ~r_prio);
  assign w_gnt1 = w_idle & req1_valid & (~req0_valid |  r_prio);

  assign w_last = (r_idx == IW'(NSLICE - 1));

  // Chunk select as an explicit decode so the index never needs a
  // width-extended multiply.
  always_comb begin
    w_su_a = 3'b000;
    w_su_b = 3'b000;
    if (w_run) begin
      for (int k = 0; k < NSLICE; k++) begin
        if (r_idx == IW'(k)) begin
          w_su_a = r_a[3*k +: 3];
          w_su_b = r_b[3*k +: 3];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_a     <= w_gnt1 ? req1_a : req0_a;
            r_b     <= w_gnt1 ? req1_b : req0_b;
            r_id    <= w_gnt1;
            r_prio  <= w_gnt0;   // priority moves to the requester that lost
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IW'(k)) begin
              r_y[3*k +: 3] <= su_y;
            end
          end
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SLICE_SEQ_CHECK_EN
  logic       r_err;
  logic [2:0] w_gold;

  assign w_gold = {~(w_su_a[2] | w_su_b[2]),
                   ~(w_su_a[1] | w_su_b[1]),
                   ~w_su_a[0] & w_su_b[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_run && (su_y != w_gold)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = w_done;
  assign rsp_y      = r_y;
  assign rsp_id     = r_id;
  assign su_a       = w_su_a;
  assign su_b       = w_su_b;
  assign busy       = w_run | w_done;

endmodule

// File: doc/slice_seq_arbiter.md
# slice_seq_arbiter

Two-requester controller that shares a single external 3-bit combinational slice unit. Each operand pair is 3·NSLICE bits wide and is streamed through the slice unit one 3-bit chunk per cycle, LSB chunk first. The controller reassembles the result and returns it on a valid/ready response port tagged with the requester ID. It sits between requesting logic and the slice unit and owns all sequencing, arbitration and capture.

## Interface
- NSLICE, 4, number of 3-bit chunks per operand; operand/result width W = 3·NSLICE; legal range 1..16
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester 0/1 has an operand pair
- req0_ready / req1_ready  out  1  requester 0/1 is accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  W  operands
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_y  out  W  assembled result
- rsp_id  out  1  requester that owns rsp_y
- su_a, su_b  out  3  chunk driven to the slice unit
- su_y  in  3  slice unit output, combinational from su_a/su_b
- busy  out  1  high in RUN or DONE
- err  out  1  sticky slice-check error (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational and at most one-hot. It is asserted only for the granted requester and only while that requester's valid is high.
  - On the handshake edge: capture a, b and id into registers, set idx=0, go to RUN.
- Arbitration is round-robin with a 1-bit priority pointer.
  - With both valids high, the priority requester wins.
  - With one valid high, that requester wins regardless of the pointer.
  - The pointer flips to the non-winner on every accept.
  - After reset, requester 0 has priority.
- RUN:
  - su_a = a_reg[3·idx +: 3] and su_b = b_reg[3·idx +: 3].
  - At each edge, su_y is written into y_reg[3·idx +: 3] and idx increments.
  - After the capture at idx = NSLICE−1, go to DONE.
  - idx width is clog2(NSLICE), minimum 1 bit. idx never wraps inside a transaction.
- DONE:
  - rsp_valid=1. rsp_y = y_reg and rsp_id = id_reg, both held stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new request is accepted in DONE.
- su_a/su_b are 0 outside RUN.
- Reset mid-transaction: the transaction is discarded with no response. The arbiter pointer returns to requester 0.

## Timing
- Reset values: state=IDLE, req0_ready=req1_ready=0 (with valids low), rsp_valid=0, rsp_y=0, rsp_id=0, su_a=su_b=0, busy=0, err=0.
- Accept at edge T → RUN during cycles T+1..T+NSLICE → rsp_valid high from cycle T+NSLICE+1.
- Latency is NSLICE+1 cycles, accept to response.
- Minimum issue interval is NSLICE+2 cycles, because the DONE→IDLE transition costs one cycle.
- rsp_ready held low: DONE persists indefinitely and all req_ready stay 0.
- req_valid dropping after the handshake has no effect. Operand inputs are ignored outside the accept cycle.

## Configuration
- SLICE_SEQ_CHECK_EN defined:
  - During RUN, su_y is compared against the golden slice function: y[2]=~(a[2]|b[2]), y[1]=~(a[1]|b[1]), y[0]=~a[0]&b[0].
  - Any mismatch sets err on the next edge. err stays set until rst.
- Not defined:
  - err is tied to 0 and no comparator logic exists.
  - The datapath is otherwise identical.

## Test plan
- NSLICE=4: req0 with a=12'h000, b=12'h000 → rsp_valid 5 cycles after accept, rsp_y=12'hDB6, rsp_id=0.
- req1 with a=12'h000, b=12'hFFF → rsp_y=12'h249, rsp_id=1. With a=12'hFFF, b=12'hFFF → rsp_y=12'h000.
- Both valids high continuously from reset:
  - Grants alternate 0,1,0,1.
  - Each req_ready pulse is one cycle and never overlaps the other.
  - Successive accepts are 6 cycles apart with rsp_ready=1.
- rsp_ready low for 10 cycles in DONE:
  - rsp_y/rsp_id stay stable and no req_ready is asserted.
  - Release → IDLE next cycle.
- rst asserted in the 2nd RUN cycle → next cycle IDLE, busy=0, su_a=su_b=0, no response. A subsequent req1-only request is still accepted.
- With SLICE_SEQ_CHECK_EN, bench slice model forces su_y=3'b000 on the chunk-2 cycle → err rises on the following edge and remains 1 until rst.
